// File: rtl/pingpong_fill_ctrl.sv
// -----------------------------------------------------------------------------
// pingpong_fill_ctrl
//
// Write-side controller for the ECG ping-pong sample buffer. Incoming samples
// are written, one per valid cycle, into the bank currently owned by the
// writer. When a frame is complete and the reader has released the other
// bank, the banks are swapped: `switch` toggles and `frame_ready` pulses to
// hand the full frame to the reader.
//
// Ports
//   clk          : single clock for the whole block
//   rst_n        : asynchronous, active-low reset
//   enable       : 1 = acquisition running
//   sample_valid : one sample offered this cycle (no backpressure)
//   sample_data  : sample value
//   rd_done      : 1-cycle pulse from the reader, finished with its bank
//   fu_addra     : write address into the active bank (registered)
//   fu_wea       : write strobe into the active bank (registered)
//   dt_an        : write data (registered)
//   switch       : bank select into switching_block
//   frame_ready  : 1-cycle pulse, full frame handed to the reader
//   rd_busy      : reader holds the non-active bank
//   overrun_cnt  : samples dropped while waiting for the reader (saturating)
// -----------------------------------------------------------------------------
module pingpong_fill_ctrl #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int FRAME_LEN = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              rd_done,
  output logic [ADDR_W-1:0] fu_addra,
  output logic              fu_wea,
  output logic [DATA_W-1:0] dt_an,
  output logic              switch,
  output logic              frame_ready,
  output logic              rd_busy,
  output logic [15:0]       overrun_cnt
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FILL     = 2'd1,
    WAIT_RDR = 2'd2
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] wp_reg;
  // Set for exactly one cycle after the last sample of a frame is accepted
  // with the reader free; the bank flips at the end of that cycle so the
  // final write of the old frame lands before `switch` changes.
  logic              swap_pend_reg;

  logic accept;
  logic last_accept;
  logic reader_free;
  logic swap_fire;

  assign accept      = (state_reg == FILL) && enable && sample_valid;
  assign last_accept = accept && (wp_reg == LAST_ADDR);
  assign reader_free = !rd_busy || rd_done;
  // A swap out of WAIT_RDR fires directly in the rd_done cycle; a swap out
  // of FILL fires one cycle after the last accept. A pending FILL swap still
  // completes if enable drops, since that frame is already full.
  assign swap_fire   = swap_pend_reg ||
                       ((state_reg == WAIT_RDR) && enable && rd_done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      wp_reg        <= '0;
      swap_pend_reg <= 1'b0;
      fu_addra      <= '0;
      fu_wea        <= 1'b0;
      dt_an         <= '0;
      switch        <= 1'b0;
      frame_ready   <= 1'b0;
      rd_busy       <= 1'b0;
      overrun_cnt   <= '0;
    end else begin
      // Registered write port: one cycle of latency from accept to bus.
      fu_wea <= accept;
      if (accept) begin
        fu_addra <= wp_reg;
        dt_an    <= sample_data;
      end

      swap_pend_reg <= 1'b0;
      frame_ready   <= swap_fire;
      if (swap_fire) begin
        switch <= ~switch;
      end

      // The reader is handed a bank on every swap. An rd_done that arrives
      // together with the last accept is consumed by the swap it enables,
      // so the reader is considered busy throughout.
      if (swap_fire) begin
        rd_busy <= 1'b1;
      end else if (rd_done && !last_accept) begin
        rd_busy <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          wp_reg <= '0;
          if (enable) begin
            state_reg <= FILL;
          end
        end

        FILL: begin
          if (!enable) begin
            state_reg <= IDLE;
            wp_reg    <= '0;
          end else if (accept) begin
            if (last_accept) begin
              wp_reg <= '0;
              if (reader_free) begin
                swap_pend_reg <= 1'b1;
              end else begin
                state_reg <= WAIT_RDR;
              end
            end else begin
              wp_reg <= wp_reg + ADDR_W'(1);
            end
          end
        end

        WAIT_RDR: begin
          if (!enable) begin
            state_reg <= IDLE;
            wp_reg    <= '0;
          end else begin
            if (sample_valid && (overrun_cnt != 16'hFFFF)) begin
              overrun_cnt <= overrun_cnt + 16'd1;
            end
            if (rd_done) begin
              state_reg <= FILL;
            end
          end
        end

        default: begin
          state_reg <= IDLE;
          wp_reg    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pingpong_fill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pingpong_fill_ctrl
//
// Directed bench for pingpong_fill_ctrl with FRAME_LEN=8. Stimulus pushes the
// expected bus writes and frame handovers into queues; an independent monitor
// pops and compares them whenever the DUT shows fu_wea or frame_ready.
// -----------------------------------------------------------------------------
module tb_pingpong_fill_ctrl;

  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 32;
  localparam int FRAME_LEN = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic              sample_valid;
  logic [DATA_W-1:0] sample_data;
  logic              rd_done;
  logic [ADDR_W-1:0] fu_addra;
  logic              fu_wea;
  logic [DATA_W-1:0] dt_an;
  logic              switch;
  logic              frame_ready;
  logic              rd_busy;
  logic [15:0]       overrun_cnt;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              sw;
  } wr_t;

  wr_t  wr_q[$];
  logic fr_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  pingpong_fill_ctrl #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .FRAME_LEN(FRAME_LEN)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .sample_valid(sample_valid),
    .sample_data (sample_data),
    .rd_done     (rd_done),
    .fu_addra    (fu_addra),
    .fu_wea      (fu_wea),
    .dt_an       (dt_an),
    .switch      (switch),
    .frame_ready (frame_ready),
    .rd_busy     (rd_busy),
    .overrun_cnt (overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input int a, input logic sw);
    wr_t e;
    e.addr = ADDR_W'(a);
    e.data = d;
    e.sw   = sw;
    wr_q.push_back(e);
    sample_valid = 1'b1;
    sample_data  = d;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fu_wea"},      32'(fu_wea),      32'd0);
    check({tag, "_fu_addra"},    32'(fu_addra),    32'd0);
    check({tag, "_dt_an"},       dt_an,            32'd0);
    check({tag, "_switch"},      32'(switch),      32'd0);
    check({tag, "_frame_ready"}, 32'(frame_ready), 32'd0);
    check({tag, "_rd_busy"},     32'(rd_busy),     32'd0);
    check({tag, "_overrun_cnt"}, 32'(overrun_cnt), 32'd0);
  endtask

  // Monitor: compares every bus write and every frame handover against the
  // expectations queued by the stimulus.
  initial begin
    forever begin
      @(negedge clk);
      if (fu_wea === 1'b1) begin
        if (wr_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write: got addr=%0d data=0x%0h sw=%0b, expected no write",
                   fu_addra, dt_an, switch);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          $display("write addr=%0d data=0x%08h sw=%0b", fu_addra, dt_an, switch);
          check("write_addr",   32'(fu_addra), 32'(e.addr));
          check("write_data",   dt_an,         e.data);
          check("write_switch", 32'(switch),   32'(e.sw));
        end
      end
      if (frame_ready === 1'b1) begin
        if (fr_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_frame_ready: got pulse with sw=%0b, expected none", switch);
        end else begin
          logic exp_sw;
          exp_sw = fr_q.pop_front();
          $display("frame_ready sw=%0b", switch);
          check("frame_switch", 32'(switch), 32'(exp_sw));
        end
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    enable       = 1'b0;
    sample_valid = 1'b0;
    sample_data  = '0;
    rd_done      = 1'b0;
    tick();
    tick();
    check_all_zero("reset_init");
    rst_n = 1'b1;
    tick();

    // Partial frame, then asynchronous reset between clock edges.
    enable = 1'b1;
    tick();
    send(32'hA000_0000, 0, 1'b0);
    send(32'hA000_0001, 1, 1'b0);
    #5;
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    check_all_zero("reset_async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Test 1: three accepts land at addresses 0,1,2.
    enable = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) send(32'h100 + i, i, 1'b0);

    // Test 2: complete the frame with the reader free.
    fr_q.push_back(1'b1);
    for (int i = 3; i < 8; i++) send(32'h100 + i, i, 1'b0);
    check("t2_frame_ready_not_yet", 32'(frame_ready), 32'd0);
    check("t2_switch_before",       32'(switch),      32'd0);
    check("t2_last_addr",           32'(fu_addra),    32'd7);
    send(32'h108, 0, 1'b1);
    check("t2_frame_ready", 32'(frame_ready), 32'd1);
    check("t2_switch_after", 32'(switch),     32'd1);
    check("t2_rd_busy",      32'(rd_busy),    32'd1);

    // Test 3: second frame fills with the reader still busy -> drops.
    for (int i = 1; i < 8; i++) send(32'h108 + i, i, 1'b1);
    for (int i = 0; i < 5; i++) begin
      sample_valid = 1'b1;
      sample_data  = 32'hDEAD_0000 + i;
      tick();
      check("t3_no_write", 32'(fu_wea), 32'd0);
    end
    sample_valid = 1'b0;
    check("t3_overrun_cnt", 32'(overrun_cnt), 32'd5);
    check("t3_switch",      32'(switch),      32'd1);
    check("t3_rd_busy",     32'(rd_busy),     32'd1);

    // Test 4: reader releases while waiting -> swap next cycle.
    fr_q.push_back(1'b0);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    check("t4_switch",      32'(switch),      32'd0);
    check("t4_frame_ready", 32'(frame_ready), 32'd1);
    check("t4_rd_busy",     32'(rd_busy),     32'd1);
    send(32'h200, 0, 1'b0);

    // Test 5: rd_done together with the last accept -> immediate swap.
    for (int i = 1; i < 7; i++) send(32'h200 + i, i, 1'b0);
    fr_q.push_back(1'b1);
    rd_done = 1'b1;
    send(32'h207, 7, 1'b0);
    rd_done = 1'b0;
    send(32'h208, 0, 1'b1);
    check("t5_switch",      32'(switch),      32'd1);
    check("t5_frame_ready", 32'(frame_ready), 32'd1);
    check("t5_rd_busy",     32'(rd_busy),     32'd1);
    check("t5_overrun_cnt", 32'(overrun_cnt), 32'd5);

    // Test 6: drop enable mid-frame, samples ignored while idle.
    for (int i = 1; i < 4; i++) send(32'h208 + i, i, 1'b1);
    enable = 1'b0;
    tick();
    sample_valid = 1'b1;
    sample_data  = 32'hBAD0_0001;
    tick();
    check("t6_idle_no_write", 32'(fu_wea), 32'd0);
    enable      = 1'b1;
    sample_data = 32'hBAD0_0002;
    tick();
    check("t6_enable_cycle_no_write", 32'(fu_wea), 32'd0);
    sample_valid = 1'b0;
    check("t6_switch_hold",  32'(switch),      32'd1);
    check("t6_rd_busy_hold", 32'(rd_busy),     32'd1);
    check("t6_overrun_hold", 32'(overrun_cnt), 32'd5);
    send(32'h300, 0, 1'b1);
    check("t6_restart_addr",   32'(fu_addra), 32'd0);
    check("t6_restart_switch", 32'(switch),   32'd1);

    for (int i = 0; i < 4; i++) tick();
    check("wr_q_drained", 32'(wr_q.size()), 32'd0);
    check("fr_q_drained", 32'(fr_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
